// File: rtl/boundary_pkg.sv
// Shared types and constants for the boundary update controller.
package boundary_pkg;

  localparam int COORD_W = 11;
  localparam int DIFF_W  = 12;
  localparam int DIST_W  = 23;
  localparam int SQ_W    = 22;
  localparam int MISS_W  = 4;

  localparam int TL_X  = 0;
  localparam int TL_Y  = 1;
  localparam int TR_X  = 2;
  localparam int TR_Y  = 3;
  localparam int BL_X  = 4;
  localparam int BL_Y  = 5;
  localparam int BR_X  = 6;
  localparam int BR_Y  = 7;
  localparam int N_CRD = 8;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    SQ_X,
    SQ_Y,
    CHECK,
    WAIT_VBLANK
  } state_t;

endpackage

// File: rtl/boundary_update_ctrl_frame_tick_gen.sv
// One-cycle strobe when the VGA line counter first reaches vblank.
module frame_tick_gen
  import boundary_pkg::*;
#(
  parameter int p_frame_height = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] vga_y,
  output logic               frame_tick
);

  localparam coord_t VB = COORD_W'(p_frame_height);

  coord_t vga_y_q;

  always_ff @(posedge clk) begin
    if (reset) vga_y_q <= '0;
    else       vga_y_q <= vga_y;
  end

  assign frame_tick = (vga_y == VB) && (vga_y_q != VB);

endmodule

// File: rtl/boundary_update_ctrl.sv
// Accepts corner sets, measures the top edge, and commits
// them to the active registers only at vblank start.
module boundary_update_ctrl
  import boundary_pkg::*;
#(
  parameter int p_frame_height = 480,
  parameter int p_hold_frames  = 8,
  parameter int p_min_dist     = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               corners_valid,
  output logic               corners_ready,
  input  logic [COORD_W-1:0] top_left_x,
  input  logic [COORD_W-1:0] top_left_y,
  input  logic [COORD_W-1:0] top_right_x,
  input  logic [COORD_W-1:0] top_right_y,
  input  logic [COORD_W-1:0] bot_left_x,
  input  logic [COORD_W-1:0] bot_left_y,
  input  logic [COORD_W-1:0] bot_right_x,
  input  logic [COORD_W-1:0] bot_right_y,
  input  logic [COORD_W-1:0] VGA_Y,
  output logic [COORD_W-1:0] act_top_left_x,
  output logic [COORD_W-1:0] act_top_left_y,
  output logic [COORD_W-1:0] act_top_right_x,
  output logic [COORD_W-1:0] act_top_right_y,
  output logic [COORD_W-1:0] act_bot_left_x,
  output logic [COORD_W-1:0] act_bot_left_y,
  output logic [COORD_W-1:0] act_bot_right_x,
  output logic [COORD_W-1:0] act_bot_right_y,
  output logic [DIST_W-1:0]  scale_dist,
  output logic               draw_enable,
  output logic               commit_pulse
);

  localparam logic [MISS_W-1:0] HOLD = MISS_W'(p_hold_frames);
  localparam logic [DIST_W-1:0] MIN_D = DIST_W'(p_min_dist);

  state_t state, state_nx;
  coord_t pend [N_CRD];
  coord_t act  [N_CRD];

  logic [DIST_W-1:0] acc;
  logic [MISS_W-1:0] miss_cnt, miss_nx;
  logic frame_tick, accept, commit, miss;

  logic signed [DIFF_W-1:0] dx, dy, mul_a;
  logic [SQ_W-1:0] mul_ext, sq;

  frame_tick_gen #(
    .p_frame_height(p_frame_height)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .vga_y     (VGA_Y),
    .frame_tick(frame_tick)
  );

  assign dx = {1'b0, pend[TR_X]} - {1'b0, pend[TL_X]};
  assign dy = {1'b0, pend[TR_Y]} - {1'b0, pend[TL_Y]};

  // One multiplier serves both squares; the low 22 bits of the
  // sign-extended product are exact since |d|^2 < 2^22.
  assign mul_a   = (state == SQ_X) ? dx : dy;
  assign mul_ext = {{(SQ_W-DIFF_W){mul_a[DIFF_W-1]}}, mul_a};
  assign sq      = mul_ext * mul_ext;

  assign miss    = frame_tick && (state != WAIT_VBLANK);
  assign miss_nx = (miss_cnt == HOLD) ? miss_cnt
                                      : miss_cnt + 1'b1;

  always_comb begin
    state_nx      = state;
    corners_ready = 1'b0;
    accept        = 1'b0;
    commit        = 1'b0;
    unique case (state)
      IDLE: begin
        corners_ready = !reset;
        accept        = corners_valid && !reset;
        if (accept) state_nx = SQ_X;
      end
      SQ_X:  state_nx = SQ_Y;
      SQ_Y:  state_nx = CHECK;
      CHECK: state_nx = (acc < MIN_D) ? IDLE : WAIT_VBLANK;
      WAIT_VBLANK: begin
        if (frame_tick) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CRD; i++) begin
        act[i]  <= '0;
        pend[i] <= '0;
      end
      acc          <= '0;
      scale_dist   <= '0;
      miss_cnt     <= HOLD;
      draw_enable  <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= commit;
      if (accept) begin
        pend[TL_X] <= top_left_x;
        pend[TL_Y] <= top_left_y;
        pend[TR_X] <= top_right_x;
        pend[TR_Y] <= top_right_y;
        pend[BL_X] <= bot_left_x;
        pend[BL_Y] <= bot_left_y;
        pend[BR_X] <= bot_right_x;
        pend[BR_Y] <= bot_right_y;
      end
      if (state == SQ_X) acc <= {1'b0, sq};
      if (state == SQ_Y) acc <= acc + {1'b0, sq};
      if (commit) begin
        act         <= pend;
        scale_dist  <= acc;
        miss_cnt    <= '0;
        draw_enable <= 1'b1;
      end else if (miss) begin
        miss_cnt <= miss_nx;
        if (miss_nx == HOLD) draw_enable <= 1'b0;
      end
    end
  end

  assign act_top_left_x  = act[TL_X];
  assign act_top_left_y  = act[TL_Y];
  assign act_top_right_x = act[TR_X];
  assign act_top_right_y = act[TR_Y];
  assign act_bot_left_x  = act[BL_X];
  assign act_bot_left_y  = act[BL_Y];
  assign act_bot_right_x = act[BR_X];
  assign act_bot_right_y = act[BR_Y];

endmodule

// File: tb/tb_boundary_update_ctrl.sv
// Random and directed bench for boundary_update_ctrl against
// a cycle-level behavioural model of accept/commit/miss rules.
module tb_boundary_update_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        corners_valid = 1'b0;
  logic        corners_ready;
  logic [10:0] cin [8];
  logic [10:0] VGA_Y = 11'd460;
  logic [10:0] act_o [8];
  logic [22:0] scale_dist;
  logic        draw_enable;
  logic        commit_pulse;

  int tests = 0;
  int fails = 0;
  int pos = 0;

  boundary_update_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .corners_valid  (corners_valid),
    .corners_ready  (corners_ready),
    .top_left_x     (cin[0]),
    .top_left_y     (cin[1]),
    .top_right_x    (cin[2]),
    .top_right_y    (cin[3]),
    .bot_left_x     (cin[4]),
    .bot_left_y     (cin[5]),
    .bot_right_x    (cin[6]),
    .bot_right_y    (cin[7]),
    .VGA_Y          (VGA_Y),
    .act_top_left_x (act_o[0]),
    .act_top_left_y (act_o[1]),
    .act_top_right_x(act_o[2]),
    .act_top_right_y(act_o[3]),
    .act_bot_left_x (act_o[4]),
    .act_bot_left_y (act_o[5]),
    .act_bot_right_x(act_o[6]),
    .act_bot_right_y(act_o[7]),
    .scale_dist     (scale_dist),
    .draw_enable    (draw_enable),
    .commit_pulse   (commit_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Line sequence per 42-cycle frame: 460..479, 480 x3, 481..499.
  function automatic int yof(int p);
    if (p < 20) return 460 + p;
    if (p < 23) return 480;
    return 458 + p;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      pos   = (pos == 41) ? 0 : pos + 1;
      VGA_Y = 11'(yof(pos));
    end
  end

  // Behavioural model
  bit mv = 0;
  int m_set [8];
  int m_act [8];
  int m_pdist, m_scale, m_age, m_miss, m_prev;
  bit m_busy, m_draw, m_pulse;

  always @(posedge clk) begin
    bit tick, was_idle;
    int dx, dy;
    if (reset) begin
      mv = 1;
      foreach (m_act[i]) m_act[i] = 0;
      m_scale = 0; m_miss = 8; m_draw = 0;
      m_pulse = 0; m_busy = 0; m_prev = 0;
    end else begin
      tick = (VGA_Y == 480) && (m_prev != 480);
      m_prev = VGA_Y;
      was_idle = !m_busy;
      m_pulse = 0;
      if (m_busy && m_age >= 3) begin
        if (tick) begin
          foreach (m_act[i]) m_act[i] = m_set[i];
          m_scale = m_pdist; m_miss = 0;
          m_draw = 1; m_pulse = 1; m_busy = 0;
        end
      end else begin
        if (tick) begin
          if (m_miss < 8) m_miss++;
          if (m_miss == 8) m_draw = 0;
        end
        if (m_busy) begin
          if (m_age == 2 && m_pdist < 100) m_busy = 0;
          else m_age++;
        end
      end
      if (was_idle && corners_valid) begin
        foreach (m_set[i]) m_set[i] = cin[i];
        dx = m_set[2] - m_set[0];
        dy = m_set[3] - m_set[1];
        m_pdist = dx * dx + dy * dy;
        m_busy = 1; m_age = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      for (int i = 0; i < 8; i++)
        chk($sformatf("act[%0d]", i), act_o[i], m_act[i]);
      chk("scale_dist", scale_dist, m_scale);
      chk("draw_enable", draw_enable, m_draw);
      chk("commit_pulse", commit_pulse, m_pulse);
      chk("corners_ready", corners_ready,
          int'(!reset && !m_busy));
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic steps(int n);
    repeat (n) step();
  endtask

  task automatic wait_pos(int p);
    int k = 0;
    do begin step(); k++; end while (pos != p && k < 200);
    if (pos != p) chk("wait_pos", pos, p);
  endtask

  task automatic set_c(int a, int b, int c, int d);
    cin[0] = 11'(a); cin[1] = 11'(b);
    cin[2] = 11'(c); cin[3] = 11'(d);
    for (int i = 4; i < 8; i++)
      cin[i] = 11'($urandom_range(0, 2047));
  endtask

  task automatic present();
    bit r;
    int k = 0;
    corners_valid = 1'b1;
    do begin r = corners_ready; step(); k++; end
    while (!r && k < 200);
    corners_valid = 1'b0;
    if (!r) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin step(); n++; end
    while (!commit_pulse && n < 200);
    if (!commit_pulse) chk("pulse_timeout", 0, 1);
  endtask

  function automatic int rnd_near(int base);
    int v = base + int'($urandom_range(0, 9));
    return (v > 2047) ? 2047 : v;
  endfunction

  initial begin
    int n, a, b, c, d;
    for (int i = 0; i < 8; i++) cin[i] = '0;
    steps(3);
    reset = 1'b0;
    step();
    chk("rst_ready", corners_ready, 1);
    chk("rst_draw", draw_enable, 0);
    chk("rst_scale", scale_dist, 0);
    repeat (20) wait_pos(21);
    chk("idle_draw", draw_enable, 0);
    chk("idle_act_tlx", act_o[0], 0);

    wait_pos(5);
    set_c(100, 50, 180, 110);
    present();
    chk("mid_frame_hold", scale_dist, 0);
    wait_pulse(n);
    chk("c1_scale", scale_dist, 10000);
    chk("c1_model", m_scale, 10000);
    chk("c1_tlx", act_o[0], 100);
    chk("c1_draw", draw_enable, 1);
    step();
    chk("c1_pulse_len", commit_pulse, 0);

    wait_pos(2);
    set_c(300, 200, 305, 203);
    present();
    chk("rej_model_dist", m_pdist, 34);
    steps(2);
    chk("rej_ready_c2", corners_ready, 0);
    step();
    chk("rej_ready_c3", corners_ready, 1);
    chk("rej_keep", scale_dist, 10000);

    wait_pos(18);
    set_c(10, 10, 40, 50);
    present();
    wait_pulse(n);
    chk("late_latency", n, 44);
    chk("late_scale", scale_dist, 2500);

    for (int f = 1; f <= 12; f++) begin
      wait_pos(21);
      chk($sformatf("hold_f%0d", f), draw_enable,
          int'(f < 8));
      chk($sformatf("hold_miss%0d", f), m_miss,
          (f < 8) ? f : 8);
    end
    wait_pos(5);
    set_c(500, 500, 600, 500);
    present();
    wait_pulse(n);
    chk("restore_draw", draw_enable, 1);
    chk("restore_scale", scale_dist, 10000);

    wait_pos(5);
    set_c(0, 0, 2047, 0);
    present();
    steps(5);
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    step();
    chk("abort_scale", scale_dist, 0);
    chk("abort_trx", act_o[2], 0);
    chk("abort_ready", corners_ready, 1);
    wait_pos(21);
    chk("abort_nocommit", scale_dist, 0);

    wait_pos(5);
    set_c(0, 0, 2047, 0);
    present();
    wait_pulse(n);
    chk("wrap_pos", scale_dist, 4190209);
    wait_pos(5);
    set_c(2047, 0, 0, 0);
    present();
    wait_pulse(n);
    chk("wrap_neg", scale_dist, 4190209);
    chk("wrap_neg_trx", act_o[2], 0);

    repeat (300) begin
      steps($urandom_range(0, 30));
      if ($urandom_range(0, 19) == 0) steps(400);
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b1;
        steps($urandom_range(1, 3));
        reset = 1'b0;
      end
      a = $urandom_range(0, 2047);
      b = $urandom_range(0, 2047);
      if ($urandom_range(0, 2) == 0) begin
        c = rnd_near(a);
        d = rnd_near(b);
      end else begin
        c = $urandom_range(0, 2047);
        d = $urandom_range(0, 2047);
      end
      set_c(a, b, c, d);
      if ($urandom_range(0, 3) == 0) begin
        corners_valid = 1'b1;
        step();
        corners_valid = 1'b0;
      end else begin
        present();
      end
    end
    steps(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
